// File: rtl/if_fetch_pkg.sv
// Shared fetch-unit constants: bus widths, polarity encodings, FIFO depth.
// Imported by if_fetch and if_fetch_fifo.
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        BblDisable  = 1'b0;
  localparam logic        Branch      = 1'b1;
  localparam int          FetchDepth  = 2;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry fetch buffer: sync flush, push/pop, count and head outputs.
// Ports: clk, rst, flush_i, push_i, pop_i, data_i -> cnt_o, head_o.
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [1:0]   cnt_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (push_i && pop_i) begin
      // count unchanged; head advances, new word lands behind it
      if (cnt_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = data_i;
      end else begin
        e0_d = data_i;
      end
    end else if (push_i) begin
      if (cnt_q == 2'd0) e0_d = data_i;
      else               e1_d = data_i;
      cnt_d = cnt_q + 2'd1;
    end else if (pop_i) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = e0_q;

  // the issue logic never requests a word it has no room for
  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst)
    push_i |-> (cnt_q != 2'(FetchDepth))
  );

endmodule

// File: rtl/if_fetch.sv
// Fetch front end: PC, imem req/ack handshake, 2-deep word buffer.
// Ports: bbl/branch in; imem_req/addr/ack/rdata; if_pc/if_inst/stallreq out.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int               AddrW   = InstAddrBus,
  parameter int               InstW   = InstBus,
  parameter logic [AddrW-1:0] ResetPc = AddrW'(ZeroWord)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bbl,
  input  logic             branch_flag_i,
  input  logic [AddrW-1:0] branch_target_i,
  output logic             imem_req_o,
  output logic [AddrW-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [InstW-1:0] imem_rdata_i,
  output logic [AddrW-1:0] if_pc,
  output logic [InstW-1:0] if_inst,
  output logic             stallreq_o
);

  logic [AddrW-1:0]       pc_q, pc_d;
  logic [AddrW-1:0]       addr_q, addr_d;
  logic                   req_q, req_d;
  logic                   kill_q, kill_d;
  logic [AddrW-1:0]       tgt;
  logic [1:0]             cnt, cnt_nx;
  logic [AddrW+InstW-1:0] head;
  logic                   done, redir;
  logic                   accept, pop;
  logic                   outst_nx;

  assign tgt      = {branch_target_i[AddrW-1:2], 2'b00};
  assign redir    = (branch_flag_i == Branch) && (bbl == BblDisable);
  assign done     = req_q & imem_ack_i;
  assign accept   = done & ~kill_q & ~redir;
  assign pop      = (cnt != 2'd0) && (bbl == BblDisable)
                  && (branch_flag_i != Branch);
  assign outst_nx = req_q & ~imem_ack_i;
  assign cnt_nx   = redir ? 2'd0
                  : cnt + {1'b0, accept} - {1'b0, pop};

  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    req_d  = req_q;
    kill_d = kill_q;
    if (accept) pc_d = addr_q + AddrW'(4);
    if (redir) begin
      pc_d = tgt;
      if (outst_nx) begin
        // in-flight word belongs to the old path; drop it on arrival
        kill_d = 1'b1;
      end else begin
        kill_d = 1'b0;
        req_d  = 1'b1;
        addr_d = tgt;
      end
    end else if (done && kill_q) begin
      // pc already holds the redirect target
      kill_d = 1'b0;
      req_d  = 1'b1;
      addr_d = pc_q;
    end else if (!outst_nx && cnt_nx < 2'(FetchDepth)) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end else if (done) begin
      req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      pc_q   <= ResetPc;
      addr_q <= '0;
      req_q  <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      req_q  <= req_d;
      kill_q <= kill_d;
    end
  end

  if_fetch_fifo #(
    .W(AddrW + InstW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(redir),
    .push_i (accept),
    .pop_i  (pop),
    .data_i ({addr_q, imem_rdata_i}),
    .cnt_o  (cnt),
    .head_o (head)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign stallreq_o  = (cnt == 2'd0);
  assign if_pc   = stallreq_o ? '0 : head[AddrW+InstW-1:InstW];
  assign if_inst = stallreq_o ? '0 : head[InstW-1:0];

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: random-latency memory, expected in-order stream.
// Monitor compares FIFO head against the predicted sequential stream.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bbl = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  int compared = 0;
  int mismatched = 0;

  // expected delivery stream: {pc, inst}
  logic [63:0] exp_q[$];
  logic [31:0] nxt_pc = 32'h0;

  int lat_fix = 0;
  int rnd_lat = 0;
  int wcnt = 0;
  logic pend = 1'b0;
  logic [31:0] held = '0;
  int starve = 0;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .bbl            (bbl),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .stallreq_o     (stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill();
    while (exp_q.size() < 4) begin
      exp_q.push_back({nxt_pc, mem_word(nxt_pc)});
      nxt_pc = nxt_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // memory: decides ack/data for the coming edge, checks addr stability
  always @(posedge clk) begin
    #1;
    if (rst) begin
      imem_ack_i = 1'b0;
      pend = 1'b0;
      wcnt = 0;
    end else begin
      if (pend) begin
        chk("req_held", {31'b0, imem_req_o}, 32'd1);
        chk("addr_stable", imem_addr_o, held);
      end
      if (imem_req_o) begin
        if (wcnt >= ((lat_fix < 0) ? rnd_lat : lat_fix)) begin
          imem_ack_i = 1'b1;
          imem_rdata_i = mem_word(imem_addr_o);
          wcnt = 0;
          rnd_lat = $urandom_range(3);
          pend = 1'b0;
        end else begin
          imem_ack_i = 1'b0;
          imem_rdata_i = $urandom;
          wcnt++;
          pend = 1'b1;
          held = imem_addr_o;
        end
      end else begin
        // stray acks with no request must be ignored
        imem_ack_i = ($urandom_range(3) == 0);
        imem_rdata_i = $urandom;
        pend = 1'b0;
        wcnt = 0;
      end
    end
  end

  // monitor: head vs expected stream; consume on pop, restart on redirect
  always @(negedge clk) begin
    if (!rst) begin
      if (branch_flag_i && !bbl) begin
        exp_q.delete();
        nxt_pc = {branch_target_i[31:2], 2'b00};
      end else begin
        fill();
        if (!stallreq_o) begin
          chk("if_pc", if_pc, exp_q[0][63:32]);
          chk("if_inst", if_inst, exp_q[0][31:0]);
          if (!bbl) void'(exp_q.pop_front());
        end else begin
          chk("empty_zero", if_pc | if_inst, 32'h0);
        end
      end
      if (stallreq_o && !bbl) starve++;
      else starve = 0;
      if (starve > 40) begin
        chk("starved", 32'd1, 32'd0);
        starve = 0;
      end
    end
  end

  initial begin
    logic [31:0] old;
    bit hit;
    #1;
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'd1);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    step();
    step();
    rst = 1'b0;
    lat_fix = 0;
    step();
    chk("first_req", {31'b0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);
    step();
    chk("first_word", if_pc, 32'h0);
    repeat (10) begin
      step();
      chk("no_bubble", {31'b0, stallreq_o}, 32'd0);
    end

    // stall: buffer fills, request drops, head holds
    bbl = 1'b1;
    repeat (5) step();
    chk("bbl_req_off", {31'b0, imem_req_o}, 32'd0);
    bbl = 1'b0;
    repeat (10) step();

    // slow memory
    lat_fix = 3;
    repeat (30) step();

    // redirect while a request is in flight
    lat_fix = 2;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_req_o && !imem_ack_i) hit = 1;
      else step();
    end
    chk("inflight_found", {31'b0, hit}, 32'd1);
    old = imem_addr_o;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    chk("kill_hold", imem_addr_o, old);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      if (imem_req_o && imem_addr_o == 32'h100) hit = 1;
    end
    chk("kill_retarget", {31'b0, hit}, 32'd1);
    repeat (15) step();

    // redirect on an ack edge
    lat_fix = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_req_o && imem_ack_i) hit = 1;
      else step();
    end
    chk("ack_found", {31'b0, hit}, 32'd1);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h203;
    step();
    branch_flag_i = 1'b0;
    chk("redir_req", {31'b0, imem_req_o}, 32'd1);
    chk("redir_addr", imem_addr_o, 32'h200);
    chk("redir_empty", {31'b0, stallreq_o}, 32'd1);
    repeat (10) step();

    // redirect during stall is ignored
    bbl = 1'b1;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h500;
    repeat (4) step();
    branch_flag_i = 1'b0;
    bbl = 1'b0;
    repeat (6) step();

    // reset mid-transaction
    lat_fix = 3;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", if_pc, 32'h0);
    chk("mid_rst_inst", if_inst, 32'h0);
    chk("mid_rst_stall", {31'b0, stallreq_o}, 32'd1);
    chk("mid_rst_req", {31'b0, imem_req_o}, 32'd0);
    exp_q.delete();
    nxt_pc = 32'h0;
    step();
    rst = 1'b0;
    step();
    chk("rst2_req", {31'b0, imem_req_o}, 32'd1);
    chk("rst2_addr", imem_addr_o, 32'h0);
    repeat (10) step();

    // random traffic
    lat_fix = -1;
    repeat (2000) begin
      bbl = ($urandom_range(99) < 30);
      branch_flag_i = ($urandom_range(99) < 6);
      branch_target_i = $urandom & 32'h0000_0FFF;
      step();
    end
    bbl = 1'b0;
    branch_flag_i = 1'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end. Generates the PC, runs a req/ack handshake with instruction memory, and buffers returned words in a 2-entry FIFO.
- Presents if_pc/if_inst to the IF/ID pipeline register.
- Honours the same bbl (stall) and branch_flag_i redirect semantics that IF/ID uses, so wrong-path words are never delivered.

Parameters:
- ResetPc, 32'h0000_0000, first fetch address after reset.
- AddrW, 32, instruction address width (`InstAddrBus).
- InstW, 32, instruction width (`InstBus).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bbl  in  1  pipeline stall; 1 = IF/ID holds, so nothing is consumed.
- branch_flag_i  in  1  redirect request, honoured only when bbl=0.
- branch_target_i  in  AddrW  redirect address.
- imem_req_o  out  1  fetch request, registered.
- imem_addr_o  out  AddrW  fetch address, registered, stable while req=1.
- imem_ack_i  in  1  one-cycle ack; data is valid in the same cycle; may come in the first cycle req is high.
- imem_rdata_i  in  InstW  fetched word.
- if_pc  out  AddrW  PC of the FIFO head, 0 when empty.
- if_inst  out  InstW  word at the FIFO head, 0 (NOP) when empty.
- stallreq_o  out  1  1 when the FIFO is empty (fetch starved).

Behaviour:
- Reset (asynchronous, immediate):
  - pc = ResetPc.
  - imem_req_o = 0 and imem_addr_o = 0.
  - FIFO count = 0 and kill = 0.
  - if_pc = 0, if_inst = 0, stallreq_o = 1.
  - First edge after release: req <= 1, addr <= ResetPc.
- Handshake:
  - A transaction completes on an edge where req=1 and ack=1.
  - An ack while req=0 is ignored.
  - At most one transaction is outstanding.
  - addr does not change while a request is outstanding.
- Accept: a completing transaction with kill=0 and no redirect this edge pushes {addr, rdata} to the FIFO; pc <= addr + 4, wrapping modulo 2^AddrW.
- Pop: on an edge with count>0, bbl=0 and branch_flag_i=0.
- Issue rule, evaluated every edge:
  - outstanding_next = req & ~ack.
  - cnt_next = count + accept - pop.
  - If ~outstanding_next and cnt_next < 2: req <= 1, addr <= next pc. Otherwise, if the transaction completed, req <= 0.
  - Result: with a same-cycle ack and bbl=0, throughput is 1 word per cycle.
- Redirect, on an edge where branch_flag_i=1 and bbl=0:
  - FIFO is flushed (count <= 0).
  - pc <= {branch_target_i[AddrW-1:2], 2'b00}.
  - If a request is outstanding and not acked this edge: kill <= 1, and req/addr stay on the old address.
  - Otherwise (no request, or ack this edge): data is discarded and req <= 1, addr <= target at this edge.
- Kill: the next completing ack is discarded, kill <= 0, and req/addr move to the target on the same edge.
- If branch_flag_i=1 while bbl=1, it is ignored.
- If bbl=1, fetching continues until the FIFO is full (count=2); FIFO contents are held.
- Simultaneous push and pop: allowed; count is unchanged.
- Push when full: cannot occur by construction; assert in simulation.
- Outputs:
  - if_pc and if_inst are combinational from the FIFO head when count>0, else zero.
  - stallreq_o = (count==0).
- Redirect with kill pending: a second redirect before the ack only updates pc; kill stays 1.

Decomposition:
- Shared defines:
  - `RstEnable
  - `InstAddrBus
  - `InstBus
  - `ZeroWord
  - `BblDisable
  - `Branch
  - new: `FetchDepth (2)
- Sub-module fetch_fifo: 2-entry FIFO with synchronous flush, push/pop, count output and head output.
- The top level holds pc, req/addr, kill and the issue logic.

Test Plan:
- Reset release, memory acks every cycle in the same cycle, bbl=0 → req high from the first edge; if_pc = 0x0, 0x4, 0x8 on consecutive cycles; stallreq_o=0 after the first word.
- bbl=1 held for 5 cycles → exactly 2 words are buffered (0x0, 0x4); req drops; if_pc holds 0x0; on release the words are delivered in order with no loss.
- 3-cycle ack latency → addr stays stable for 3 cycles; stallreq_o=1 while empty; each word is delivered once.
- Redirect to 0x100 (bbl=0) while a request to 0x8 is in flight with latency 2 → the 0x8 data is dropped; next req addr=0x100; first if_pc=0x100.
- Redirect to 0x203 on an ack edge → the acked word is discarded; addr=0x200 on the same edge; the FIFO is empty the next cycle.
- branch_flag_i=1 with bbl=1 → ignored, the FIFO is unchanged. Then rst is pulsed mid-transaction → immediate zero outputs; a fresh request to ResetPc goes out after release.
